// File: rtl/audio_channel_sequencer.sv
// Eight-voice sample sequencer sharing one single-port ROM.
// Fetches one sample per slot per tick and commits a full 8-lane frame.
module audio_channel_sequencer #(
  parameter int WIDTH = 8,
  parameter int ADDR_W = 14,
  parameter int LEN_W = 12,
  parameter logic [WIDTH-1:0] SILENCE = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_tick,
  input  logic [7:0]          trig,
  input  logic [7:0]          loop,
  input  logic [8*ADDR_W-1:0] chan_base,
  input  logic [8*LEN_W-1:0]  chan_len,
  output logic                rom_rd,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [WIDTH-1:0]    rom_data,
  output logic [8*WIDTH-1:0]  channel_out,
  output logic                frame_done,
  output logic [7:0]          active,
  output logic                busy,
  output logic                overrun
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t             state;
  logic [2:0]         slot;
  logic [7:0]         pending;
  logic [LEN_W-1:0]   pos [8];
  logic [8*WIDTH-1:0] shadow;
  logic [8*WIDTH-1:0] shadow_n;

  logic               start;
  logic               res_en;
  logic               cap_en;
  logic               cap_last;
  logic [2:0]         res_slot;
  logic [2:0]         cap_slot;
  logic [ADDR_W-1:0]  res_base;
  logic [LEN_W-1:0]   res_len;
  logic [LEN_W-1:0]   cap_len;
  logic [WIDTH-1:0]   cap_val;

  // Slot k resolves at the edge entering FETCH k; its data lands two edges later.
  always_comb begin
    start    = (state == IDLE) && sample_tick && !frame_done;
    res_slot = (state == IDLE) ? 3'd0 : slot + 3'd1;
    res_en   = start || ((state == FETCH) && (slot != 3'd7));
    cap_slot = (state == DRAIN) ? 3'd7 : slot - 3'd1;
    cap_en   = ((state == FETCH) && (slot != 3'd0)) || (state == DRAIN);
    res_base = chan_base[int'(res_slot)*ADDR_W +: ADDR_W];
    res_len  = chan_len[int'(res_slot)*LEN_W +: LEN_W];
    cap_len  = chan_len[int'(cap_slot)*LEN_W +: LEN_W];
    cap_last = (pos[cap_slot] == cap_len - LEN_W'(1));
    cap_val  = active[cap_slot] ? rom_data : SILENCE;
    shadow_n = shadow;
    if (cap_en)
      shadow_n[int'(cap_slot)*WIDTH +: WIDTH] = cap_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      slot        <= 3'd0;
      pending     <= 8'd0;
      active      <= 8'd0;
      for (int i = 0; i < 8; i++)
        pos[i] <= '0;
      shadow      <= {8{SILENCE}};
      channel_out <= {8{SILENCE}};
      rom_rd      <= 1'b0;
      rom_addr    <= '0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      rom_rd     <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= sample_tick && (busy || frame_done);
      pending    <= pending | trig;
      shadow     <= shadow_n;

      if (cap_en && active[cap_slot]) begin
        if (cap_last) begin
          pos[cap_slot] <= '0;
          if (!loop[cap_slot])
            active[cap_slot] <= 1'b0;
        end else begin
          pos[cap_slot] <= pos[cap_slot] + LEN_W'(1);
        end
      end

      if (res_en) begin
        state    <= FETCH;
        slot     <= res_slot;
        rom_rd   <= 1'b1;
        busy     <= 1'b1;
        rom_addr <= res_base + ADDR_W'(pos[res_slot]);
        if (pending[res_slot]) begin
          // A trigger landing on the consuming edge stays armed.
          pending[res_slot] <= trig[res_slot];
          pos[res_slot]     <= '0;
          active[res_slot]  <= (res_len != '0);
          rom_addr          <= res_base;
        end
      end else if (state == FETCH) begin
        state <= DRAIN;
      end else if (state == DRAIN) begin
        state       <= IDLE;
        busy        <= 1'b0;
        frame_done  <= 1'b1;
        channel_out <= shadow_n;
      end
    end
  end

endmodule

// File: tb/tb_audio_channel_sequencer.sv
// Bench for audio_channel_sequencer: directed frames, scoreboarded
// frame and ROM-address expectations checked by a negedge monitor.
module tb_audio_channel_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         sample_tick;
  logic [7:0]   trig;
  logic [7:0]   loop;
  logic [111:0] chan_base;
  logic [95:0]  chan_len;
  logic         rom_rd;
  logic [13:0]  rom_addr;
  logic [7:0]   rom_data;
  logic [63:0]  channel_out;
  logic         frame_done;
  logic [7:0]   active;
  logic         busy;
  logic         overrun;

  audio_channel_sequencer dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick),
    .trig(trig), .loop(loop),
    .chan_base(chan_base), .chan_len(chan_len),
    .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data),
    .channel_out(channel_out), .frame_done(frame_done),
    .active(active), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [16384];
  always @(posedge clk)
    if (rom_rd) rom_data <= rom[rom_addr];

  typedef struct {
    logic [63:0] out;
    logic [7:0]  act;
  } frm_t;
  typedef struct {
    bit          care;
    logic [13:0] addr;
  } adr_t;

  frm_t fq[$];
  adr_t aq[$];
  frm_t me;
  adr_t ma;
  int total = 0;
  int bad = 0;
  logic [63:0] prev_out;

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    if (frame_done === 1'b1) begin
      if (fq.size() == 0) begin
        total++; bad++;
        $display("FAIL frame_extra got=frame_done want=none t=%0t", $time);
      end else begin
        me = fq.pop_front();
        chk("frame_out", channel_out, me.out);
        chk("frame_active", {56'd0, active}, {56'd0, me.act});
      end
    end
    if (rom_rd === 1'b1) begin
      if (aq.size() == 0) begin
        total++; bad++;
        $display("FAIL rom_rd_extra got=1 want=0 t=%0t", $time);
      end else begin
        ma = aq.pop_front();
        if (ma.care) chk("rom_addr", {50'd0, rom_addr}, {50'd0, ma.addr});
      end
    end
  end

  task automatic set_ch(input int k, input logic [13:0] b,
                        input logic [11:0] l);
    chan_base[k*14 +: 14] = b;
    chan_len[k*12 +: 12]  = l;
  endtask

  task automatic pulse(input logic [7:0] v);
    @(posedge clk); #1 trig = v;
    @(posedge clk); #1 trig = 8'd0;
  endtask

  task automatic reset_dut();
    @(posedge clk); #1 rst = 1'b1;
    trig = 0; loop = 0; chan_base = 0; chan_len = 0; sample_tick = 0;
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b0;
    prev_out = 64'd0;
  endtask

  // One tick in cycle n, then cycles n+1..n+12 checked cycle by cycle.
  task automatic frame(input logic [63:0] eo, input logic [7:0] ea,
                       input int wch, input logic [13:0] wa,
                       input int xt, input int tc, input logic [7:0] tv);
    frm_t f;
    adr_t a;
    f.out = eo; f.act = ea;
    fq.push_back(f);
    for (int k = 0; k < 8; k++) begin
      a.care = (k == wch); a.addr = wa;
      aq.push_back(a);
    end
    @(posedge clk); #1 sample_tick = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 12; c++) begin
      sample_tick = (c == xt);
      trig = (c == tc) ? tv : 8'd0;
      @(negedge clk);
      chk("rom_rd", {63'd0, rom_rd}, {63'd0, (c <= 8)});
      chk("busy", {63'd0, busy}, {63'd0, (c <= 9)});
      chk("frame_done", {63'd0, frame_done}, {63'd0, (c == 10)});
      chk("overrun", {63'd0, overrun}, {63'd0, (xt != 0 && c == xt + 1)});
      if (c < 10) chk("hold_old", channel_out, prev_out);
      if (c > 10) chk("hold_new", channel_out, eo);
      @(posedge clk); #1;
    end
    sample_tick = 1'b0;
    trig = 8'd0;
    prev_out = eo;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    adr_t a;
    rst = 1'b1; sample_tick = 0; trig = 0; loop = 0;
    chan_base = 0; chan_len = 0; prev_out = 0;
    for (int i = 0; i < 16384; i++) rom[i] = 8'(i) ^ 8'h5A;
    rom['h100] = 8'h11; rom['h101] = 8'h22; rom['h102] = 8'h33;
    rom['h200] = 8'hA0; rom['h201] = 8'hA1;
    for (int i = 0; i < 4; i++) rom['h300 + i] = 8'h31 + 8'(i);
    rom['h3FFE] = 8'h51; rom['h3FFF] = 8'h52;
    rom['h0000] = 8'h53; rom['h0001] = 8'h54;
    for (int k = 0; k < 8; k++) rom['h1000 + k*16] = 8'hFF;

    // reset and idle
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out", channel_out, 64'd0);
    chk("rst_active", {56'd0, active}, 64'd0);
    chk("rst_addr", {50'd0, rom_addr}, 64'd0);
    chk("rst_flags", {60'd0, rom_rd, busy, frame_done, overrun}, 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_rd", {63'd0, rom_rd}, 64'd0);
    end

    // single shot on ch2 plus cadence checks
    set_ch(2, 14'h100, 12'd3);
    pulse(8'h04);
    frame(64'h0000_0000_0011_0000, 8'h04, 2, 14'h100, 0, 0, 0);
    frame(64'h0000_0000_0022_0000, 8'h04, 2, 14'h101, 0, 0, 0);
    frame(64'h0000_0000_0033_0000, 8'h00, 2, 14'h102, 0, 0, 0);
    frame(64'h0, 8'h00, -1, 14'h0, 0, 0, 0);

    // loop on ch0 with overrun ticks, then drop loop
    reset_dut();
    set_ch(0, 14'h200, 12'd2);
    loop = 8'h01;
    pulse(8'h01);
    frame(64'hA0, 8'h01, 0, 14'h200, 0, 0, 0);
    frame(64'hA1, 8'h01, 0, 14'h201, 4, 0, 0);
    frame(64'hA0, 8'h01, 0, 14'h200, 10, 0, 0);
    frame(64'hA1, 8'h01, 0, 14'h201, 0, 0, 0);
    loop = 8'h00;
    frame(64'hA0, 8'h01, 0, 14'h200, 0, 0, 0);
    frame(64'hA1, 8'h00, 0, 14'h201, 0, 0, 0);
    frame(64'h0, 8'h00, -1, 14'h0, 0, 0, 0);

    // reset in the middle of a frame
    reset_dut();
    set_ch(0, 14'h200, 12'd2);
    loop = 8'h01;
    pulse(8'h01);
    frame(64'hA0, 8'h01, 0, 14'h200, 0, 0, 0);
    a.care = 1'b0; a.addr = 14'h0;
    for (int i = 0; i < 5; i++) aq.push_back(a);
    @(posedge clk); #1 sample_tick = 1'b1;
    @(posedge clk); #1 sample_tick = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    loop = 8'h00;
    for (int c = 6; c <= 16; c++) begin
      @(negedge clk);
      chk("abort_done", {63'd0, frame_done}, 64'd0);
      chk("abort_busy", {63'd0, busy}, 64'd0);
      chk("abort_rd", {63'd0, rom_rd}, 64'd0);
      chk("abort_active", {56'd0, active}, 64'd0);
      chk("abort_out", channel_out, 64'd0);
    end
    prev_out = 64'd0;
    frame(64'h0, 8'h00, -1, 14'h0, 0, 0, 0);

    // retrigger on the consuming edge of slot 3
    reset_dut();
    set_ch(3, 14'h300, 12'd4);
    pulse(8'h08);
    frame(64'h3100_0000, 8'h08, 3, 14'h300, 0, 3, 8'h08);
    frame(64'h3100_0000, 8'h08, 3, 14'h300, 0, 0, 0);
    frame(64'h3200_0000, 8'h08, 3, 14'h301, 0, 0, 0);

    // zero length never activates
    reset_dut();
    set_ch(5, 14'h500, 12'd0);
    pulse(8'h20);
    frame(64'h0, 8'h00, -1, 14'h0, 0, 0, 0);

    // address wrap
    reset_dut();
    set_ch(1, 14'h3FFE, 12'd4);
    pulse(8'h02);
    frame(64'h5100, 8'h02, 1, 14'h3FFE, 0, 0, 0);
    frame(64'h5200, 8'h02, 1, 14'h3FFF, 0, 0, 0);
    frame(64'h5300, 8'h02, 1, 14'h0000, 0, 0, 0);
    frame(64'h5400, 8'h00, 1, 14'h0001, 0, 0, 0);

    // all eight voices at once
    reset_dut();
    for (int k = 0; k < 8; k++) set_ch(k, 14'(16'h1000 + k*16), 12'd1);
    pulse(8'hFF);
    frame(64'hFFFF_FFFF_FFFF_FFFF, 8'h00, -1, 14'h0, 0, 0, 0);
    frame(64'h0, 8'h00, -1, 14'h0, 0, 0, 0);

    repeat (3) @(posedge clk);
    chk("frames_left", 64'(fq.size()), 64'd0);
    chk("addrs_left", 64'(aq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/audio_channel_sequencer.md
Name: audio_channel_sequencer

Overview:
- Sequences eight sound-effect voices that share one single-port sample ROM.
- On each sample tick it fetches one sample per active voice in fixed channel order and tracks per-voice playback position, loop and stop state.
- It then commits a coherent 8-channel frame that feeds the 8-input audio mixer directly.
- Sits between the game's sound-trigger register and the mixer/DAC path.

Parameters:
- WIDTH, 8, sample width in bits; matches the mixer channel width.
- ADDR_W, 14, sample ROM address width.
- LEN_W, 12, per-voice sample length and position counter width.
- SILENCE, 0, value driven on an inactive channel.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- sample_tick  input  1  one-cycle pulse at the audio sample rate.
- trig  input  8  per-channel start request; a one-cycle pulse, or held.
- loop  input  8  per-channel level; while high, the voice restarts at its end instead of stopping.
- chan_base  input  8*ADDR_W  ROM base address per channel; channel k is at [k*ADDR_W +: ADDR_W].
- chan_len  input  8*LEN_W  sample count per channel; channel k is at [k*LEN_W +: LEN_W].
- rom_rd  output  1  ROM read strobe.
- rom_addr  output  ADDR_W  ROM read address.
- rom_data  input  WIDTH  ROM data, valid exactly 1 cycle after rom_rd.
- channel_out  output  8*WIDTH  committed frame; channel k is at [k*WIDTH +: WIDTH].
- frame_done  output  1  one-cycle pulse when channel_out updates.
- active  output  8  per-channel playing flag.
- busy  output  1  high while a fetch sequence is in progress.
- overrun  output  1  one-cycle pulse when sample_tick arrives while busy.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset state:
  - FSM in IDLE.
  - channel_out = SILENCE on all channels.
  - active, pending, all positions = 0.
  - rom_rd = 0, rom_addr = 0.
  - frame_done, busy, overrun = 0.
  - Reset asserted mid-sequence aborts the frame; no commit and no frame_done are produced.
- FSM states: IDLE, FETCH (3-bit slot index k = 0..7), DRAIN.
- Transitions:
  - IDLE -> FETCH k=0 when sample_tick = 1.
  - FETCH k -> FETCH k+1.
  - FETCH 7 -> DRAIN.
  - DRAIN -> IDLE.
- Timing, with sample_tick high in IDLE during cycle n:
  - Cycles n+1..n+8: rom_rd = 1 and rom_addr = base_k + pos_k for slot k = 0..7.
  - rom_rd is asserted even for inactive slots; fixed cadence, addresses don't-care.
  - Cycles n+2..n+9: rom_data is captured into the shadow register for slot k-1; a slot that is inactive after resolution captures SILENCE.
  - Cycle n+10: all 8 channel_out lanes change together and frame_done = 1 for that cycle.
  - busy = 1 in cycles n+1..n+9.
- Address arithmetic: base_k + zero-extended pos_k, truncated modulo 2^ADDR_W.
- Trigger handling:
  - Any cycle with trig[i] = 1 sets pending[i].
  - Slot resolution happens at the clock edge that begins FETCH k. If pending[k] is set: pos_k = 0, active[k] = 1, pending[k] cleared, and the fetch reads base_k.
  - A retrigger while a voice is playing restarts it from 0.
  - If trig[k] = 1 in the same cycle pending[k] is consumed, set wins: pending[k] stays 1 and applies next frame.
- Zero length: a voice with chan_len = 0 never activates; pending[k] is cleared and the output is SILENCE.
- Advance, applied at the capture cycle of an active slot k:
  - If pos_k == len_k - 1 and loop[k] = 1: pos_k <- 0.
  - If pos_k == len_k - 1 and loop[k] = 0: active[k] <- 0 and pos_k <- 0. The last sample is still output this frame.
  - Otherwise pos_k <- pos_k + 1.
- loop[k] is sampled only at that capture edge.
- Overrun: sample_tick while busy = 1, or in the frame_done cycle, is dropped; the sequence is not restarted and overrun pulses for 1 cycle.
- Between frames: channel_out holds its value.
- Parameter changes: chan_base and chan_len are assumed static while busy; changes take effect at the next slot resolution.

Test Plan:
- Reset then idle:
  - rst 2 cycles, no ticks -> channel_out all 0, active = 0, rom_rd never 1.
  - Reset asserted at cycle n+5 of a frame -> no frame_done, all state cleared.
- Single shot:
  - Stimulus: ch2 base = 0x100, len = 3, ROM[0x100..0x102] = 0x11, 0x22, 0x33; trig[2] pulse, then 4 ticks.
  - Lane 2 reads 0x11, 0x22, 0x33, then 0x00 (SILENCE).
  - active[2] falls after the third frame.
  - rom_addr in slot 2 = 0x100, 0x101, 0x102.
- Loop:
  - Stimulus: ch0 len = 2, data 0xA0, 0xA1, loop[0] held 1, 5 ticks.
  - Lane 0 sequence: A0, A1, A0, A1, A0.
  - Drop loop after frame 4 -> voice stops after the next A1.
- Timing:
  - Tick at cycle n -> rom_rd high exactly n+1..n+8 and busy n+1..n+9.
  - frame_done only at n+10; all 8 lanes change in that same cycle.
- Collisions:
  - Tick at n+4 -> overrun pulse, frame_done only at n+10.
  - trig[3] high at the slot-3 start edge while pending[3] = 1 -> voice restarts this frame and restarts again next frame.
- Edge cases:
  - chan_len = 0 with trig -> active stays 0, lane outputs SILENCE.
  - base = 0x3FFE, len = 4 -> addresses 3FFE, 3FFF, 0000, 0001.
  - All 8 channels active at 0xFF -> every lane outputs 0xFF.
